// File: rtl/mac_accumulator_64b_if.sv
// Product-in / block-sum-out handshake bundle for the MAC accumulator.
// slave is the accumulator's view, master is the producer/consumer side.
interface mac_accumulator_64b_if #(
    parameter int PRODUCT_WIDTH = 64,
    parameter int ACC_WIDTH     = 72,
    parameter int CNT_WIDTH     = 4
);
    logic [PRODUCT_WIDTH-1:0] product_64b;
    logic                     product_valid;
    logic                     product_ready;
    logic                     flush;
    logic [ACC_WIDTH-1:0]     sum_acc;
    logic [CNT_WIDTH-1:0]     sum_count;
    logic                     sum_overflow;
    logic                     sum_valid;
    logic                     sum_ready;

    modport slave (
        input  product_64b, product_valid, flush, sum_ready,
        output product_ready, sum_acc, sum_count, sum_overflow, sum_valid
    );

    modport master (
        output product_64b, product_valid, flush, sum_ready,
        input  product_ready, sum_acc, sum_count, sum_overflow, sum_valid
    );
endinterface

// File: rtl/mac_accumulator_64b.sv
// Sums blocks of BLOCK_LEN products into a wide accumulator and hands each
// block sum, count and sticky overflow downstream over valid/ready.
//
// state    | meaning
// ST_ACCUM | accepting products into acc_q
// ST_DONE  | block sum presented, waiting for sum_ready
module mac_accumulator_64b #(
    parameter int PRODUCT_WIDTH = 64,
    parameter int ACC_WIDTH     = 72,
    parameter int BLOCK_LEN     = 8,
    parameter int CNT_WIDTH     = 4
) (
    input  logic                 clk_64b,
    input  logic                 reset_64b,
    mac_accumulator_64b_if.slave bus
);
    localparam int AW1 = ACC_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BLOCK_LEN - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]   sum_acc_q, sum_acc_d;
    logic [CNT_WIDTH-1:0]   sum_count_q, sum_count_d;
    logic                   sum_ovf_q, sum_ovf_d;
    logic                   accept;
    logic [AW1-1:0]         acc_ext;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum_acc_d   = sum_acc_q;
        sum_count_d = sum_count_q;
        sum_ovf_d   = sum_ovf_q;
        accept      = (state_q == ST_ACCUM) && bus.product_valid;
        // Extra top bit carries the wrap-out used for the sticky overflow.
        acc_ext     = {1'b0, acc_q} + AW1'(bus.product_64b);

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = acc_ext[ACC_WIDTH-1:0];
                    cnt_d = cnt_q + 1'b1;
                    ovf_d = ovf_q | acc_ext[ACC_WIDTH];
                end
                if ((accept && (cnt_q == LAST_CNT)) ||
                    (bus.flush && ((cnt_q != '0) || accept))) begin
                    state_d     = ST_DONE;
                    sum_acc_d   = acc_d;
                    sum_count_d = cnt_d;
                    sum_ovf_d   = ovf_d;
                end
            end
            ST_DONE: begin
                if (bus.sum_ready) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk_64b) begin
        if (reset_64b) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_acc_q   <= '0;
            sum_count_q <= '0;
            sum_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            sum_acc_q   <= sum_acc_d;
            sum_count_q <= sum_count_d;
            sum_ovf_q   <= sum_ovf_d;
        end
    end

    assign bus.product_ready = (state_q == ST_ACCUM);
    assign bus.sum_valid     = (state_q == ST_DONE);
    assign bus.sum_acc       = sum_acc_q;
    assign bus.sum_count     = sum_count_q;
    assign bus.sum_overflow  = sum_ovf_q;
endmodule

// File: tb/tb_mac_accumulator_64b.sv
// Directed table plus hand sequences and a random scoreboard run against
// three accumulator configurations sharing one clock and reset.
module tb_mac_accumulator_64b;
    logic clk_64b   = 1'b0;
    logic reset_64b = 1'b1;
    always #5 clk_64b = ~clk_64b;

    mac_accumulator_64b_if #(.PRODUCT_WIDTH(64), .ACC_WIDTH(72), .CNT_WIDTH(4)) if_a ();
    mac_accumulator_64b_if #(.PRODUCT_WIDTH(64), .ACC_WIDTH(64), .CNT_WIDTH(4)) if_b ();
    mac_accumulator_64b_if #(.PRODUCT_WIDTH(64), .ACC_WIDTH(72), .CNT_WIDTH(4)) if_c ();

    mac_accumulator_64b #(.PRODUCT_WIDTH(64), .ACC_WIDTH(72), .BLOCK_LEN(4), .CNT_WIDTH(4))
        u_a (.clk_64b(clk_64b), .reset_64b(reset_64b), .bus(if_a));
    mac_accumulator_64b #(.PRODUCT_WIDTH(64), .ACC_WIDTH(64), .BLOCK_LEN(2), .CNT_WIDTH(4))
        u_b (.clk_64b(clk_64b), .reset_64b(reset_64b), .bus(if_b));
    mac_accumulator_64b #(.PRODUCT_WIDTH(64), .ACC_WIDTH(72), .BLOCK_LEN(8), .CNT_WIDTH(4))
        u_c (.clk_64b(clk_64b), .reset_64b(reset_64b), .bus(if_c));

    typedef struct {
        logic [63:0] p;
        logic        v;
        logic        fl;
        logic        sr;
        logic        e_rdy;
        logic        e_sv;
        logic [71:0] e_acc;
        logic [3:0]  e_cnt;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(logic [63:0] p, logic v, logic fl, logic sr,
                                logic e_rdy, logic e_sv, logic [71:0] e_acc,
                                logic [3:0] e_cnt, logic e_ovf);
        vec_t r;
        r.p = p; r.v = v; r.fl = fl; r.sr = sr;
        r.e_rdy = e_rdy; r.e_sv = e_sv; r.e_acc = e_acc; r.e_cnt = e_cnt; r.e_ovf = e_ovf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_64b);
        #1;
    endtask

    task automatic chk_out_c(input string tag, input logic rdy, input logic sv,
                             input logic [71:0] acc, input logic [3:0] cnt, input logic ovf);
        chk({tag, ".rdy"}, 128'(if_c.product_ready), 128'(rdy));
        chk({tag, ".sv"},  128'(if_c.sum_valid), 128'(sv));
        chk({tag, ".acc"}, 128'(if_c.sum_acc), 128'(acc));
        chk({tag, ".cnt"}, 128'(if_c.sum_count), 128'(cnt));
        chk({tag, ".ovf"}, 128'(if_c.sum_overflow), 128'(ovf));
    endtask

    initial begin
        logic [127:0] total;
        int           n, gap, wait_cyc, dly;
        logic [63:0]  pv;

        if_a.product_64b = '0; if_a.product_valid = 0; if_a.flush = 0; if_a.sum_ready = 0;
        if_b.product_64b = '0; if_b.product_valid = 0; if_b.flush = 0; if_b.sum_ready = 0;
        if_c.product_64b = '0; if_c.product_valid = 0; if_c.flush = 0; if_c.sum_ready = 0;

        // BLOCK_LEN=4 script: full blocks, backpressure, flush cases, gaps
        tbl.push_back(mk(64'd1,   1, 0, 0, 1, 0, 72'd0,  4'd0, 0));
        tbl.push_back(mk(64'd2,   1, 0, 0, 1, 0, 72'd0,  4'd0, 0));
        tbl.push_back(mk(64'd3,   1, 0, 0, 1, 0, 72'd0,  4'd0, 0));
        tbl.push_back(mk(64'd4,   1, 0, 0, 1, 0, 72'd0,  4'd0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(64'd99, 1, 0, 0, 0, 1, 72'd10, 4'd4, 0));
        tbl.push_back(mk(64'd0,   0, 0, 1, 0, 1, 72'd10, 4'd4, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(64'd5, 1, 0, 0, 1, 0, 72'd10, 4'd4, 0));
        tbl.push_back(mk(64'd0,   0, 0, 1, 0, 1, 72'd20, 4'd4, 0));
        tbl.push_back(mk(64'd5,   1, 0, 0, 1, 0, 72'd20, 4'd4, 0));
        tbl.push_back(mk(64'd6,   1, 0, 0, 1, 0, 72'd20, 4'd4, 0));
        tbl.push_back(mk(64'd7,   1, 1, 0, 1, 0, 72'd20, 4'd4, 0));
        tbl.push_back(mk(64'd0,   0, 0, 1, 0, 1, 72'd18, 4'd3, 0));
        tbl.push_back(mk(64'd0,   0, 1, 0, 1, 0, 72'd18, 4'd3, 0));
        tbl.push_back(mk(64'd0,   0, 0, 0, 1, 0, 72'd18, 4'd3, 0));
        tbl.push_back(mk(64'd100, 1, 0, 0, 1, 0, 72'd18, 4'd3, 0));
        tbl.push_back(mk(64'd555, 0, 0, 0, 1, 0, 72'd18, 4'd3, 0));
        tbl.push_back(mk(64'd200, 1, 1, 0, 1, 0, 72'd18, 4'd3, 0));
        tbl.push_back(mk(64'd0,   0, 1, 0, 0, 1, 72'd300, 4'd2, 0));
        tbl.push_back(mk(64'd0,   0, 0, 1, 0, 1, 72'd300, 4'd2, 0));
        tbl.push_back(mk(64'd11,  1, 0, 0, 1, 0, 72'd300, 4'd2, 0));
        tbl.push_back(mk(64'd0,   0, 1, 0, 1, 0, 72'd300, 4'd2, 0));
        tbl.push_back(mk(64'd0,   0, 0, 1, 0, 1, 72'd11, 4'd1, 0));
        tbl.push_back(mk(64'd0,   0, 0, 0, 1, 0, 72'd11, 4'd1, 0));

        step(); step();
        chk("rst.a.sv",  128'(if_a.sum_valid), 128'(0));
        chk("rst.a.acc", 128'(if_a.sum_acc), 128'(0));
        chk("rst.b.cnt", 128'(if_b.sum_count), 128'(0));
        chk("rst.c.ovf", 128'(if_c.sum_overflow), 128'(0));
        reset_64b = 0;
        step();
        chk_out_c("rst.c", 1, 0, 72'd0, 4'd0, 0);
        chk("rst.a.rdy", 128'(if_a.product_ready), 128'(1));

        foreach (tbl[i]) begin
            if_a.product_64b   = tbl[i].p;
            if_a.product_valid = tbl[i].v;
            if_a.flush         = tbl[i].fl;
            if_a.sum_ready     = tbl[i].sr;
            chk($sformatf("tbl%0d.rdy", i), 128'(if_a.product_ready), 128'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d.sv", i),  128'(if_a.sum_valid), 128'(tbl[i].e_sv));
            chk($sformatf("tbl%0d.acc", i), 128'(if_a.sum_acc), 128'(tbl[i].e_acc));
            chk($sformatf("tbl%0d.cnt", i), 128'(if_a.sum_count), 128'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.ovf", i), 128'(if_a.sum_overflow), 128'(tbl[i].e_ovf));
            step();
        end
        if_a.product_valid = 0; if_a.flush = 0; if_a.sum_ready = 0;

        // 64-bit accumulator wrap with BLOCK_LEN=2, then overflow cleared by handoff
        if_b.product_valid = 1; if_b.product_64b = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        if_b.product_64b = 64'd2;
        step();
        if_b.product_valid = 0;
        chk("wrap.sv",  128'(if_b.sum_valid), 128'(1));
        chk("wrap.rdy", 128'(if_b.product_ready), 128'(0));
        chk("wrap.acc", 128'(if_b.sum_acc), 128'(1));
        chk("wrap.cnt", 128'(if_b.sum_count), 128'(2));
        chk("wrap.ovf", 128'(if_b.sum_overflow), 128'(1));
        if_b.sum_ready = 1; step(); if_b.sum_ready = 0;
        chk("wrap.drop", 128'(if_b.sum_valid), 128'(0));
        if_b.product_valid = 1; if_b.product_64b = 64'd3;
        step();
        if_b.product_64b = 64'd4;
        step();
        if_b.product_valid = 0;
        chk("wrap2.acc", 128'(if_b.sum_acc), 128'(7));
        chk("wrap2.ovf", 128'(if_b.sum_overflow), 128'(0));
        chk("wrap2.sv",  128'(if_b.sum_valid), 128'(1));
        if_b.sum_ready = 1; step(); if_b.sum_ready = 0;

        // Reset mid-block discards the partial sum
        if_c.product_valid = 1; if_c.product_64b = 64'd9;
        step(); step();
        if_c.product_valid = 0;
        reset_64b = 1;
        step();
        reset_64b = 0;
        chk_out_c("midrst", 1, 0, 72'd0, 4'd0, 0);
        for (int k = 1; k <= 8; k++) begin
            if_c.product_valid = 1; if_c.product_64b = 64'(k);
            step();
        end
        if_c.product_valid = 0;
        chk_out_c("after_rst", 0, 1, 72'd36, 4'd8, 0);
        if_c.sum_ready = 1; step(); if_c.sum_ready = 0;

        // Random blocks with valid gaps and sum_ready stalls against an exact-sum model
        for (int blk = 0; blk < 100; blk++) begin
            n = $urandom_range(1, 8);
            total = '0;
            for (int i = 0; i < n; i++) begin
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    if_c.product_valid = 0;
                    if_c.product_64b   = {$urandom, $urandom};
                    step();
                end
                pv = {$urandom, $urandom};
                if_c.product_valid = 1;
                if_c.product_64b   = pv;
                if_c.flush = (i == n - 1) && ((n < 8) || ($urandom_range(0, 1) == 1));
                total = total + 128'(pv);
                step();
            end
            if_c.product_valid = 0;
            if_c.flush = 0;
            wait_cyc = 0;
            while (!if_c.sum_valid && wait_cyc < 5) begin
                step();
                wait_cyc++;
            end
            chk($sformatf("rnd%0d.lat", blk), 128'(wait_cyc), 128'(0));
            dly = $urandom_range(0, 3);
            for (int d = 0; d < dly; d++) step();
            chk($sformatf("rnd%0d.acc", blk), 128'(if_c.sum_acc), 128'(total[71:0]));
            chk($sformatf("rnd%0d.cnt", blk), 128'(if_c.sum_count), 128'(n));
            chk($sformatf("rnd%0d.ovf", blk), 128'(if_c.sum_overflow), 128'(total >= (128'd1 << 72)));
            if_c.sum_ready = 1; step(); if_c.sum_ready = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_accumulator_64b.md
Name: mac_accumulator_64b

Overview:
- Downstream consumer of the 32x32 LUT multiplier's 64-bit product.
- Accepts one product per cycle over a valid/ready handshake and sums blocks of BLOCK_LEN products into a wide accumulator.
- Presents each block sum, its product count and a sticky overflow flag on a valid/ready output port.
- Serves as the accumulate half of the multiply-accumulate datapath.

Parameters:
- PRODUCT_WIDTH, 64, width of incoming product; zero-extended into the accumulator.
- ACC_WIDTH, 72, accumulator/sum width. Must be >= PRODUCT_WIDTH.
- BLOCK_LEN, 8, products per block. Legal range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 4, width of the product counter and sum_count.

Ports:
- clk_64b  in  1  single clock; all state updates on rising edge.
- reset_64b  in  1  synchronous, active-high reset.
- product_64b  in  PRODUCT_WIDTH  product from the multiplier.
- product_valid  in  1  product_64b is valid this cycle.
- product_ready  out  1  block can accept a product this cycle.
- flush  in  1  close the current block early.
- sum_acc  out  ACC_WIDTH  block sum.
- sum_count  out  CNT_WIDTH  number of products in the block.
- sum_overflow  out  1  a carry left ACC_WIDTH during the block.
- sum_valid  out  1  sum_acc, sum_count and sum_overflow are valid.
- sum_ready  in  1  downstream accepts the sum.

Behaviour:
- Clock/reset: one clock, clk_64b. reset_64b is synchronous and active-high; it overrides all other inputs.
- Reset state: state=ACCUM; acc=0, cnt=0, ovf=0; sum_valid=0, sum_acc=0, sum_count=0, sum_overflow=0. product_ready=1 from the first cycle after reset deasserts.
- States:
  - ACCUM: product_ready=1, sum_valid=0.
  - DONE: product_ready=0, sum_valid=1.
- Accept: a product is accepted when product_valid && product_ready, in ACCUM only.
  - On accept: acc <= acc + zero_ext(product_64b) mod 2^ACC_WIDTH; cnt <= cnt+1; ovf <= ovf | carry_out.
- ACCUM -> DONE when either holds:
  - (a) accept with cnt == BLOCK_LEN-1;
  - (b) flush=1 and (cnt>0 or accept this cycle).
- Flush combined with accept: the accepted product is included in the sum.
- Flush with cnt==0 and no accept: ignored; stays in ACCUM with no output.
- Flush in DONE: ignored.
- Output registers:
  - On entering DONE, sum_acc/sum_count/sum_overflow take the final acc/cnt/ovf, including any product accepted that cycle.
  - They hold stable while sum_valid=1 and sum_ready=0.
- DONE -> ACCUM on sum_ready=1. That same edge clears acc, cnt and ovf to 0 and drops sum_valid.
  - No product is accepted in DONE, so minimum throughput is one bubble per block.
  - After sum_valid drops, sum_* outputs keep their last values.
- Latency: the last product accepted at edge N gives sum_valid=1 after edge N, i.e. in cycle N+1.
- Input stability: product_valid may toggle freely; gaps do not affect the sum. product_64b is ignored when not accepted.
- Overflow: sum wraps modulo 2^ACC_WIDTH. sum_overflow is sticky per block and cleared only by block handoff or reset. With the default widths overflow is unreachable for BLOCK_LEN<=255.
- Reset mid-block or in DONE: partial sum discarded, no sum emitted; return to the reset state on the next edge.
- sum_count: equals BLOCK_LEN for a full block and 1..BLOCK_LEN-1 for a flushed block. It is never 0.

Test Plan:
1. BLOCK_LEN=4, back-to-back products 1,2,3,4 -> sum_valid in the cycle after the 4th accept; sum_acc=10, sum_count=4, sum_overflow=0; product_ready=0 while sum_valid=1.
2. Scenario 1 with sum_ready held low 5 cycles -> sum_acc stays 10 and product_ready stays 0; on release, the next block of 5,5,5,5 gives sum_acc=20 (accumulator cleared).
3. Flush: products 5,6, then 7 accepted with flush=1 in the same cycle -> sum_acc=18, sum_count=3. flush while idle with cnt=0 -> no sum_valid.
4. ACC_WIDTH=64, BLOCK_LEN=2: products 0xFFFF_FFFF_FFFF_FFFF, then 2 -> sum_acc=1, sum_overflow=1. Next block 3,4 -> sum_acc=7, sum_overflow=0.
5. Reset mid-block: accept 9,9, assert reset_64b for 1 cycle, then feed 1..8 with BLOCK_LEN=8 -> sum_acc=36, sum_count=8 (the earlier 9s are discarded).
6. Random product_valid gaps across 100 blocks of random 64-bit products vs a scoreboard model -> every sum_acc, sum_count and sum_overflow matches exactly.
